// File: rtl/crc_hash_pkg.sv
// Shared definitions for the CRC/hash engine: team polynomial and the
// accumulate/hold state encoding.
package crc_hash_pkg;

   localparam logic [63:0] HASH_POLY_DEFAULT = 64'h42F0_E1EB_A9EA_3693;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } hash_state_t;

endpackage

// File: rtl/crc_parallel_hash_engine_step.sv
// crc_lfsr_step_n: DATA_WIDTH serial LFSR steps unrolled into one
// combinational cone, MSB of the data beat consumed first.
module crc_lfsr_step_n
   import crc_hash_pkg::*;
#(
   parameter int                     HASH_LENGTH = 64,
   parameter logic [HASH_LENGTH-1:0] HASH_POLY   = HASH_POLY_DEFAULT[HASH_LENGTH-1:0],
   parameter int                     DATA_WIDTH  = 8
) (
   input  logic [HASH_LENGTH-1:0] parity_in,
   input  logic [DATA_WIDTH-1:0]  data_in,
   output logic [HASH_LENGTH-1:0] parity_out
);

   // bit 0 always takes the raw feedback, so its tap is masked off
   localparam logic [HASH_LENGTH-1:0] TAPS = {HASH_POLY[HASH_LENGTH-1:1], 1'b0};

   for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_step
      logic [HASH_LENGTH-1:0] cur;
      logic [HASH_LENGTH-1:0] nxt;
      logic                   fb;
      if (k == 0) begin : g_head
         assign cur = parity_in;
      end else begin : g_link
         assign cur = g_step[k-1].nxt;
      end
      assign fb  = data_in[DATA_WIDTH-1-k] ^ cur[HASH_LENGTH-1];
      assign nxt = {cur[HASH_LENGTH-2:0], fb} ^ ({HASH_LENGTH{fb}} & TAPS);
   end

   assign parity_out = g_step[DATA_WIDTH-1].nxt;

endmodule

// File: rtl/crc_parallel_hash_engine.sv
// Streaming CRC/hash accumulator: one beat per cycle, result held until taken.
// Build option CRC_HASH_OUT_INVERT_EN presents the inverted parity register.
module crc_parallel_hash_engine
   import crc_hash_pkg::*;
#(
   parameter int                     HASH_LENGTH = 64,
   parameter logic [HASH_LENGTH-1:0] HASH_POLY   = HASH_POLY_DEFAULT[HASH_LENGTH-1:0],
   parameter int                     DATA_WIDTH  = 8,
   parameter int                     CNT_WIDTH   = 16
) (
   input  logic                   i_clk,
   input  logic                   i_RESET,
   input  logic [DATA_WIDTH-1:0]  i_msg_data,
   input  logic                   i_msg_valid,
   input  logic                   i_msg_last,
   output logic                   o_msg_ready,
   output logic [HASH_LENGTH-1:0] o_parity,
   output logic                   o_parity_valid,
   input  logic                   i_parity_ready,
   output logic [CNT_WIDTH-1:0]   o_beat_count,
   output logic                   o_busy
);

   hash_state_t            state;
   hash_state_t            state_nxt;
   logic [HASH_LENGTH-1:0] parity_q;
   logic [HASH_LENGTH-1:0] parity_step;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic                   busy_q;
   logic                   accept;
   logic                   consume;

   crc_lfsr_step_n #(
      .HASH_LENGTH (HASH_LENGTH),
      .HASH_POLY   (HASH_POLY),
      .DATA_WIDTH  (DATA_WIDTH)
   ) u_step (
      .parity_in  (parity_q),
      .data_in    (i_msg_data),
      .parity_out (parity_step)
   );

   always_comb begin
      state_nxt      = state;
      o_msg_ready    = 1'b0;
      o_parity_valid = 1'b0;
      accept         = 1'b0;
      consume        = 1'b0;
      unique case (state)
         ACCUM: begin
            o_msg_ready = 1'b1;
            accept      = i_msg_valid;
            if (i_msg_valid && i_msg_last) state_nxt = HOLD;
         end
         HOLD: begin
            o_parity_valid = 1'b1;
            consume        = i_parity_ready;
            if (i_parity_ready) state_nxt = ACCUM;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_RESET) begin
      if (i_RESET) begin
         state    <= ACCUM;
         parity_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            parity_q <= parity_step;
            busy_q   <= 1'b1;
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
         end else if (consume) begin
            parity_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
         end
      end
   end

`ifdef CRC_HASH_OUT_INVERT_EN
   assign o_parity = ~parity_q;
`else
   assign o_parity = parity_q;
`endif

   assign o_beat_count = cnt_q;
   assign o_busy       = busy_q;

endmodule

// File: tb/tb_crc_parallel_hash_engine.sv
// Self-checking bench: CRC-8/0x07 engine via vector table and corner
// sequences, plus 64-bit engines at widths 1 and 32 against a message model.
module tb_crc_parallel_hash_engine;
   import crc_hash_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // CRC-8 engine, 4-bit counter so saturation is reachable
   logic [7:0] m_data;
   logic       m_valid, m_last, m_ready;
   logic [7:0] parity;
   logic       p_valid, p_ready;
   logic [3:0] cnt;
   logic       busy;

   crc_parallel_hash_engine #(
      .HASH_LENGTH (8),
      .HASH_POLY   (8'h07),
      .DATA_WIDTH  (8),
      .CNT_WIDTH   (4)
   ) u_dut (
      .i_clk          (clk),
      .i_RESET        (rst),
      .i_msg_data     (m_data),
      .i_msg_valid    (m_valid),
      .i_msg_last     (m_last),
      .o_msg_ready    (m_ready),
      .o_parity       (parity),
      .o_parity_valid (p_valid),
      .i_parity_ready (p_ready),
      .o_beat_count   (cnt),
      .o_busy         (busy)
   );

   logic        w1_data, w1_valid, w1_last, w1_ready;
   logic [63:0] w1_parity;
   logic        w1_pvalid, w1_pready, w1_busy;
   logic [15:0] w1_cnt;

   crc_parallel_hash_engine #(
      .HASH_LENGTH (64),
      .HASH_POLY   (HASH_POLY_DEFAULT),
      .DATA_WIDTH  (1),
      .CNT_WIDTH   (16)
   ) u_w1 (
      .i_clk          (clk),
      .i_RESET        (rst),
      .i_msg_data     (w1_data),
      .i_msg_valid    (w1_valid),
      .i_msg_last     (w1_last),
      .o_msg_ready    (w1_ready),
      .o_parity       (w1_parity),
      .o_parity_valid (w1_pvalid),
      .i_parity_ready (w1_pready),
      .o_beat_count   (w1_cnt),
      .o_busy         (w1_busy)
   );

   logic [31:0] w32_data;
   logic        w32_valid, w32_last, w32_ready;
   logic [63:0] w32_parity;
   logic        w32_pvalid, w32_pready, w32_busy;
   logic [15:0] w32_cnt;

   crc_parallel_hash_engine #(
      .HASH_LENGTH (64),
      .HASH_POLY   (HASH_POLY_DEFAULT),
      .DATA_WIDTH  (32),
      .CNT_WIDTH   (16)
   ) u_w32 (
      .i_clk          (clk),
      .i_RESET        (rst),
      .i_msg_data     (w32_data),
      .i_msg_valid    (w32_valid),
      .i_msg_last     (w32_last),
      .o_msg_ready    (w32_ready),
      .o_parity       (w32_parity),
      .o_parity_valid (w32_pvalid),
      .i_parity_ready (w32_pready),
      .o_beat_count   (w32_cnt),
      .o_busy         (w32_busy)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic timeout_fail(input string name);
      n_total++;
      $display("FAIL %s: handshake wait expired, got no ready, expected ready", name);
   endtask

   // Polynomial division of the message bit stream, MSB of each byte first.
   function automatic logic [63:0] crc_model(input logic [7:0] q[$], input int h,
                                             input logic [63:0] poly);
      logic [63:0] mask;
      logic [63:0] crc;
      logic        fb;
      mask = (h == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << h) - 64'd1);
      crc  = 64'd0;
      foreach (q[i]) begin
         for (int b = 7; b >= 0; b--) begin
            fb  = q[i][b] ^ crc[h-1];
            crc = ((crc << 1) & mask) ^ (fb ? ((poly | 64'd1) & mask) : 64'd0);
         end
      end
      return crc;
   endfunction

   // Presented value of an internal parity for the active build
   function automatic logic [63:0] ox(input logic [63:0] v, input int h);
      logic [63:0] mask;
      mask = (h == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << h) - 64'd1);
`ifdef CRC_HASH_OUT_INVERT_EN
      return ~v & mask;
`else
      return v & mask;
`endif
   endfunction

   task automatic send8(input logic [7:0] d, input logic last);
      int n = 0;
      m_valid = 1'b1;
      m_data  = d;
      m_last  = last;
      @(negedge clk);
      while (!m_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!m_ready) timeout_fail("msg_ready");
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      m_last  = 1'b0;
   endtask

   task automatic consume8(input string name);
      p_ready = 1'b1;
      @(posedge clk);
      #1;
      p_ready = 1'b0;
      check({name, "_clr_ready"}, m_ready, 1);
      check({name, "_clr_pvalid"}, p_valid, 0);
      check({name, "_clr_parity"}, parity, ox(0, 8));
      check({name, "_clr_cnt"}, cnt, 0);
      check({name, "_clr_busy"}, busy, 0);
   endtask

   task automatic check_result8(input string name, input logic [7:0] exp_p, input int exp_c);
      check({name, "_pvalid"}, p_valid, 1);
      check({name, "_ready_low"}, m_ready, 0);
      check({name, "_parity"}, parity, ox(exp_p, 8));
      check({name, "_cnt"}, cnt, exp_c[3:0]);
      check({name, "_busy"}, busy, 1);
   endtask

   typedef struct {
      int         len;
      logic [7:0] d [16];
      logic [7:0] exp_p;
      int         exp_c;
   } vec_t;

   vec_t       tbl [6];
   logic [7:0] chk [9];
   logic [7:0] q [$];
   logic [7:0] big [$];
   logic [7:0] b;
   logic [63:0] r1;
   int n;

   initial begin
      rst = 1'b1;
      m_data = '0; m_valid = 0; m_last = 0; p_ready = 0;
      w1_data = 0; w1_valid = 0; w1_last = 0; w1_pready = 0;
      w32_data = '0; w32_valid = 0; w32_last = 0; w32_pready = 0;
      for (int i = 0; i < 9; i++) chk[i] = 8'h31 + 8'(i);

      // vector table: known check values then random messages via model
      tbl[0].len = 9;
      for (int i = 0; i < 9; i++) tbl[0].d[i] = chk[i];
      tbl[0].exp_p = 8'hF4;
      tbl[0].exp_c = 9;
      tbl[1].len = 1;
      tbl[1].d[0] = 8'h01;
      tbl[1].exp_p = 8'h07;
      tbl[1].exp_c = 1;
      for (int t = 2; t < 6; t++) begin
         tbl[t].len = (t == 2) ? 15 : int'($urandom_range(2, 15));
         q = {};
         for (int i = 0; i < tbl[t].len; i++) begin
            tbl[t].d[i] = 8'($urandom);
            q.push_back(tbl[t].d[i]);
         end
         tbl[t].exp_p = crc_model(q, 8, 64'h07);
         tbl[t].exp_c = tbl[t].len;
      end

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", m_ready, 1);
      check("rst_pvalid", p_valid, 0);
      check("rst_parity", parity, ox(0, 8));
      check("rst_cnt", cnt, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < tbl[t].len; i++) begin
            send8(tbl[t].d[i], i == tbl[t].len - 1);
            if (i == 0) check($sformatf("vec%0d_busy_first", t), busy, 1);
         end
         check_result8($sformatf("vec%0d", t), tbl[t].exp_p, tbl[t].exp_c);
         consume8($sformatf("vec%0d", t));
      end

      // backpressure: stalled result with a pending beat on the input
      for (int i = 0; i < 9; i++) send8(chk[i], i == 8);
      m_valid = 1'b1; m_data = 8'h01; m_last = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("bp_ready_low", m_ready, 0);
         check("bp_parity_hold", parity, ox(8'hF4, 8));
         check("bp_cnt_hold", cnt, 9);
      end
      @(posedge clk);
      #1;
      p_ready = 1'b1;
      @(posedge clk);
      #1;
      p_ready = 1'b0;
      check("bp_release_ready", m_ready, 1);
      check("bp_release_pvalid", p_valid, 0);
      @(posedge clk);
      #1;
      m_valid = 1'b0; m_last = 1'b0;
      check_result8("bp_next", 8'h07, 1);
      consume8("bp_next");

      // reset mid-message discards the partial parity
      for (int i = 0; i < 4; i++) send8(chk[i], 1'b0);
      check("mid_cnt", cnt, 4);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_ready", m_ready, 1);
      check("mid_rst_parity", parity, ox(0, 8));
      check("mid_rst_cnt", cnt, 0);
      check("mid_rst_busy", busy, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 9; i++) send8(chk[i], i == 8);
      check_result8("replay", 8'hF4, 9);
      consume8("replay");

      // gapped valid with spurious last and ready while accumulating
      for (int i = 0; i < 9; i++) begin
         n = int'($urandom_range(0, 3));
         for (int g = 0; g < n; g++) begin
            m_valid = 1'b0;
            m_last  = 1'($urandom);
            p_ready = 1'($urandom);
            m_data  = 8'($urandom);
            @(posedge clk);
            #1;
         end
         p_ready = 1'b0;
         if (i == 5) begin
            check("gap_mid_pvalid", p_valid, 0);
            check("gap_mid_cnt", cnt, 5);
         end
         send8(chk[i], i == 8);
      end
      check_result8("gap", 8'hF4, 9);
      consume8("gap");

      // counter saturates while parity keeps accumulating
      q = {};
      for (int i = 0; i < 20; i++) begin
         b = 8'($urandom);
         q.push_back(b);
         send8(b, i == 19);
      end
      check_result8("sat", crc_model(q, 8, 64'h07), 15);
      consume8("sat");

      // width sweep on the 64-bit team polynomial
      big = {};
      for (int i = 0; i < 1024; i++) big.push_back(8'($urandom));
      r1 = crc_model(big, 64, HASH_POLY_DEFAULT);

      for (int j = 0; j < 8192; j++) begin
         w1_valid = 1'b1;
         b = big[j/8];
         w1_data = b[7 - (j % 8)];
         w1_last = (j == 8191);
         n = 0;
         @(negedge clk);
         while (!w1_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (!w1_ready) timeout_fail("w1_ready");
         @(posedge clk);
         #1;
      end
      w1_valid = 1'b0; w1_last = 1'b0;

      for (int j = 0; j < 256; j++) begin
         w32_valid = 1'b1;
         w32_data = {big[4*j], big[4*j+1], big[4*j+2], big[4*j+3]};
         w32_last = (j == 255);
         n = 0;
         @(negedge clk);
         while (!w32_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (!w32_ready) timeout_fail("w32_ready");
         @(posedge clk);
         #1;
      end
      w32_valid = 1'b0; w32_last = 1'b0;

      check("w1_pvalid", w1_pvalid, 1);
      check("w1_parity", w1_parity, ox(r1, 64));
      check("w1_cnt", w1_cnt, 16'd8192);
      check("w32_pvalid", w32_pvalid, 1);
      check("w32_parity", w32_parity, ox(r1, 64));
      check("w32_cnt", w32_cnt, 16'd256);
      check("w1_vs_w32", w1_parity, w32_parity);
      w1_pready = 1'b1; w32_pready = 1'b1;
      @(posedge clk);
      #1;
      w1_pready = 1'b0; w32_pready = 1'b0;
      check("w1_clr_busy", w1_busy, 0);
      check("w32_clr_ready", w32_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
